// File: rtl/l2_cache_nway_pkg.sv
// l2_cache_nway_pkg: shared types and helpers for the N-way L2 cache.
//   state_e  - controller states
//   cnt_w    - width of the hit/miss event counters
//   sat_inc  - saturating increment for the event counters
package l2_cache_nway_pkg;

  localparam int unsigned cnt_w = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
    return (&v) ? v : v + cnt_w'(1);
  endfunction

endpackage

// File: rtl/l2_cache_nway_plru.sv
// l2_plru_tree: combinational tree-PLRU helper for one set.
//   plru_i   - current tree bits (heap order, node 0 is the root)
//   touch_i  - way being accessed
//   plru_o   - tree bits after pointing every node on touch_i's path away from it
//   victim_o - way the current tree bits point at (bit=0 means go left)
module l2_plru_tree #(
  parameter  int unsigned s_ways   = 2,
  localparam int unsigned num_ways = 2 ** s_ways,
  localparam int unsigned plru_w   = num_ways - 1
) (
  input  logic [plru_w-1:0] plru_i,
  input  logic [s_ways-1:0] touch_i,
  output logic [plru_w-1:0] plru_o,
  output logic [s_ways-1:0] victim_o
);

  // Walk the tree root-to-leaf; the way number's MSB picks the root branch.
  always_comb begin
    int   node;
    logic dir;
    plru_o   = plru_i;
    victim_o = '0;

    node = 0;
    for (int l = 0; l < int'(s_ways); l++) begin
      dir = touch_i[int'(s_ways) - 1 - l];
      for (int n = 0; n < int'(plru_w); n++) begin
        if (n == node) plru_o[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end

    node = 0;
    for (int l = 0; l < int'(s_ways); l++) begin
      dir = 1'b0;
      for (int n = 0; n < int'(plru_w); n++) begin
        if (n == node) dir = plru_i[n];
      end
      victim_o[int'(s_ways) - 1 - l] = dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative, write-back, write-allocate L2 cache.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   mem_address/read/write     - line request from the L1 arbiter (held until mem_resp)
//   mem_wdata/byte_enable256   - write line and per-byte enables
//   mem_rdata/mem_resp         - hit-way line and one-cycle completion pulse
//   pmem_address/read/write    - line-aligned request to the cacheline adaptor
//   pmem_wdata/rdata/resp      - writeback line, fill line, adaptor completion
//   hit_count/miss_count       - saturating event counters
module l2_cache_nway
  import l2_cache_nway_pkg::*;
#(
  parameter  int unsigned s_offset = 5,
  parameter  int unsigned s_index  = 4,
  parameter  int unsigned s_ways   = 2,
  localparam int unsigned s_tag    = 32 - s_offset - s_index,
  localparam int unsigned s_mask   = 2 ** s_offset,
  localparam int unsigned s_line   = 8 * s_mask
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_line-1:0] mem_wdata,
  input  logic [s_mask-1:0] mem_byte_enable256,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [cnt_w-1:0]  hit_count,
  output logic [cnt_w-1:0]  miss_count
);

  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned num_ways = 2 ** s_ways;
  localparam int unsigned plru_w   = num_ways - 1;
  localparam int unsigned la_w     = s_tag + s_index;

  // Controller state
  state_e                 state_q, state_d;
  logic [la_w-1:0]        line_addr_q, line_addr_d;
  logic                   refill_q, refill_d;
  logic [s_ways-1:0]      victim_q, victim_d;
  logic [cnt_w-1:0]       hit_cnt_q, hit_cnt_d;
  logic [cnt_w-1:0]       miss_cnt_q, miss_cnt_d;

  // Cache arrays; data and tags are never reset
  logic [s_line-1:0]      data_q  [num_ways][num_sets];
  logic [s_tag-1:0]       tag_q   [num_ways][num_sets];
  logic [num_sets-1:0]    valid_q [num_ways];
  logic [num_sets-1:0]    dirty_q [num_ways];
  logic [plru_w-1:0]      plru_q  [num_sets];

  logic [s_index-1:0]     idx;
  logic [s_tag-1:0]       req_tag;
  logic                   req;
  logic                   hit;
  logic [s_ways-1:0]      hit_way;
  logic                   inv_found;
  logic [s_ways-1:0]      inv_way;
  logic [s_ways-1:0]      sel_victim;
  logic [plru_w-1:0]      plru_upd;
  logic [s_ways-1:0]      plru_victim;
  logic [s_line-1:0]      hit_line;
  logic [s_line-1:0]      merged_line;
  logic                   hit_upd;
  logic                   wr_hit;
  logic                   fill;
  logic                   unused_offset;

  assign idx           = line_addr_q[s_index-1:0];
  assign req_tag       = line_addr_q[s_index +: s_tag];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[s_offset-1:0];

  // Tag match and lowest-index invalid way for the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(num_ways) - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = s_ways'(w);
      end
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = s_ways'(w);
      end
    end
  end

  l2_plru_tree #(.s_ways(s_ways)) u_plru (
    .plru_i   (plru_q[idx]),
    .touch_i  (hit_way),
    .plru_o   (plru_upd),
    .victim_o (plru_victim)
  );

  assign sel_victim = inv_found ? inv_way : plru_victim;
  assign hit_line   = data_q[hit_way][idx];

  // Byte-enable merge of the write data into the hit line
  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < int'(s_mask); b++) begin
      if (mem_byte_enable256[b]) merged_line[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  // Next-state and per-cycle array update controls
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    refill_d    = refill_q;
    victim_d    = victim_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_resp    = 1'b0;
    hit_upd     = 1'b0;
    wr_hit      = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          line_addr_d = mem_address[31:s_offset];
          refill_d    = 1'b0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req) begin
          state_d = IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          hit_upd  = 1'b1;
          wr_hit   = mem_write;
          if (!refill_q) hit_cnt_d = sat_inc(hit_cnt_q);
          state_d  = IDLE;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          victim_d   = sel_victim;
          state_d    = (valid_q[sel_victim][idx] && dirty_q[sel_victim][idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          fill     = 1'b1;
          refill_d = 1'b1;
          state_d  = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded memory-side outputs; all zero in IDLE, hence during reset
  always_comb begin
    pmem_read    = (state_q == ALLOCATE);
    pmem_write   = (state_q == WRITEBACK);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == WRITEBACK) begin
      pmem_address = {tag_q[victim_q][idx], idx, {s_offset{1'b0}}};
      pmem_wdata   = data_q[victim_q][idx];
    end else if (state_q == ALLOCATE) begin
      pmem_address = {line_addr_q, {s_offset{1'b0}}};
    end
    mem_rdata = mem_resp ? hit_line : '0;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Controller and metadata registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      refill_q    <= 1'b0;
      victim_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int w = 0; w < int'(num_ways); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(num_sets); s++) plru_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      refill_q    <= refill_d;
      victim_q    <= victim_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (fill) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[hit_way][idx] <= 1'b1;
      end
      if (hit_upd) plru_q[idx] <= plru_upd;
    end
  end

  // Line data and tag storage
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[victim_q][idx] <= pmem_rdata;
      tag_q[victim_q][idx]  <= req_tag;
    end else if (wr_hit) begin
      data_q[hit_way][idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// tb_l2_cache_nway: directed self-checking bench for l2_cache_nway, built with
// two ways so that three lines mapping to set 2 force an eviction.
module tb_l2_cache_nway;

  localparam int unsigned s_offset = 5;
  localparam int unsigned s_index  = 4;
  localparam int unsigned s_ways   = 1;
  localparam int unsigned s_mask   = 2 ** s_offset;
  localparam int unsigned s_line   = 8 * s_mask;

  logic              clk;
  logic              rst_n;
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [s_line-1:0] mem_wdata;
  logic [s_mask-1:0] mem_byte_enable256;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  l2_cache_nway #(.s_offset(s_offset), .s_index(s_index), .s_ways(s_ways)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_wdata          (mem_wdata),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_rdata          (mem_rdata),
    .mem_resp           (mem_resp),
    .pmem_address       (pmem_address),
    .pmem_read          (pmem_read),
    .pmem_write         (pmem_write),
    .pmem_wdata         (pmem_wdata),
    .pmem_rdata         (pmem_rdata),
    .pmem_resp          (pmem_resp),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Results of the most recent transaction
  int          r_lat;
  int          r_pm_rd;
  int          r_pm_wr;
  logic [31:0] r_rd_addr;
  logic [31:0] r_wr_addr;
  logic [255:0] r_wr_data;
  logic [255:0] r_rdata;
  logic        r_timeout;

  logic [255:0] fill0, fill1, fill2, fill3, wdat, merged;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, act as the adaptor, and record what the cache did.
  // latency is counted from the edge that moves IDLE to LOOKUP.
  task automatic run_req(input logic [31:0] addr, input logic wr, input logic [31:0] be,
                         input logic [255:0] wd, input int wb_lat, input int rd_lat,
                         input logic [255:0] fl);
    int   cyc;
    int   pc;
    logic done;
    r_lat = -1; r_pm_rd = 0; r_pm_wr = 0; r_rd_addr = '0; r_wr_addr = '0;
    r_wr_data = '0; r_rdata = '0;
    @(posedge clk); #1;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_byte_enable256 = be; mem_wdata = wd;
    cyc = 0; pc = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      if (mem_resp) begin
        r_rdata = mem_rdata;
        r_lat   = cyc - 1;
        done    = 1'b1;
      end else if (pmem_write) begin
        if (pc == 0) begin r_pm_wr++; r_wr_addr = pmem_address; r_wr_data = pmem_wdata; end
        pc++;
        if (pc == wb_lat) begin pmem_resp = 1'b1; pc = 0; end
      end else if (pmem_read) begin
        if (pc == 0) begin r_pm_rd++; r_rd_addr = pmem_address; end
        pc++;
        if (pc == rd_lat) begin pmem_resp = 1'b1; pmem_rdata = fl; pc = 0; end
      end
    end
    r_timeout = !done;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int   waited;
    logic seen;
    total = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      fill0[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      fill1[i*32 +: 32] = 32'h2000_0000 + 32'(i);
      fill2[i*32 +: 32] = 32'h3000_0000 + 32'(i);
      fill3[i*32 +: 32] = 32'h4000_0000 + 32'(i);
    end
    wdat   = {{7{32'hFFFF_FFFF}}, 32'hDEAD_BEEF};
    merged = {fill0[255:32], 32'hDEAD_BEEF};

    rst_n = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable256 = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_resp",  256'(mem_resp), 256'(0));
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_wr",   256'(pmem_write), 256'(0));
    check("rst_pmem_addr", 256'(pmem_address), 256'(0));
    check("rst_rdata",     mem_rdata, 256'(0));
    check("rst_hits",      256'(hit_count), 256'(0));
    check("rst_misses",    256'(miss_count), 256'(0));
    rst_n = 1'b1;

    // Cold read miss, fill latency 2
    run_req(32'h0000_0040, 1'b0, 32'h0, 256'(0), 1, 2, fill0);
    check("miss1_timeout", 256'(r_timeout), 256'(0));
    check("miss1_lat",     256'(r_lat), 256'(4));
    check("miss1_rd_cnt",  256'(r_pm_rd), 256'(1));
    check("miss1_rd_addr", 256'(r_rd_addr), 256'(32'h40));
    check("miss1_wr_cnt",  256'(r_pm_wr), 256'(0));
    check("miss1_rdata",   r_rdata, fill0);
    check("miss1_misses",  256'(miss_count), 256'(1));
    check("miss1_hits",    256'(hit_count), 256'(0));

    // Read hit
    run_req(32'h0000_0040, 1'b0, 32'h0, 256'(0), 1, 1, fill3);
    check("hit1_lat",   256'(r_lat), 256'(1));
    check("hit1_rd",    256'(r_pm_rd), 256'(0));
    check("hit1_rdata", r_rdata, fill0);
    check("hit1_hits",  256'(hit_count), 256'(1));

    // Write hit on the low word, then read back the merged line
    run_req(32'h0000_0040, 1'b1, 32'h0000_000F, wdat, 1, 1, fill3);
    check("whit_lat",   256'(r_lat), 256'(1));
    check("whit_hits",  256'(hit_count), 256'(2));
    run_req(32'h0000_0044, 1'b0, 32'h0, 256'(0), 1, 1, fill3);
    check("merge_rdata", r_rdata, merged);
    check("merge_hits",  256'(hit_count), 256'(3));

    // Second line in set 2 takes the invalid way; no writeback
    run_req(32'h0000_0240, 1'b0, 32'h0, 256'(0), 1, 1, fill1);
    check("miss2_lat",     256'(r_lat), 256'(3));
    check("miss2_wr_cnt",  256'(r_pm_wr), 256'(0));
    check("miss2_rd_addr", 256'(r_rd_addr), 256'(32'h240));
    check("miss2_rdata",   r_rdata, fill1);

    // Third line evicts dirty 0x40: writeback (W=2) then fill (A=1)
    run_req(32'h0000_0440, 1'b0, 32'h0, 256'(0), 2, 1, fill2);
    check("evict_lat",     256'(r_lat), 256'(5));
    check("evict_wr_cnt",  256'(r_pm_wr), 256'(1));
    check("evict_wr_addr", 256'(r_wr_addr), 256'(32'h40));
    check("evict_wr_data", r_wr_data, merged);
    check("evict_rd_addr", 256'(r_rd_addr), 256'(32'h440));
    check("evict_rdata",   r_rdata, fill2);
    check("evict_misses",  256'(miss_count), 256'(3));

    // 0x240 survives the eviction
    run_req(32'h0000_0240, 1'b0, 32'h0, 256'(0), 1, 1, fill3);
    check("keep_lat",   256'(r_lat), 256'(1));
    check("keep_rdata", r_rdata, fill1);
    check("keep_hits",  256'(hit_count), 256'(4));

    // 0x40 misses again; PLRU must now evict clean 0x440, not 0x240
    run_req(32'h0000_0040, 1'b0, 32'h0, 256'(0), 1, 1, fill3);
    check("re40_lat",    256'(r_lat), 256'(3));
    check("re40_wr_cnt", 256'(r_pm_wr), 256'(0));
    check("re40_rdata",  r_rdata, fill3);
    run_req(32'h0000_0240, 1'b0, 32'h0, 256'(0), 1, 1, fill0);
    check("plru_lat",   256'(r_lat), 256'(1));
    check("plru_rdata", r_rdata, fill1);
    check("plru_hits",  256'(hit_count), 256'(5));
    check("plru_miss",  256'(miss_count), 256'(4));

    // Request dropped while in LOOKUP: no response, no counter change
    @(posedge clk); #1;
    mem_address = 32'h0000_0240; mem_read = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("drop_resp", 256'(mem_resp), 256'(0));
    @(negedge clk);
    check("drop_resp2", 256'(mem_resp), 256'(0));
    check("drop_pmem",  256'(pmem_read), 256'(0));
    check("drop_hits",  256'(hit_count), 256'(5));

    // Reset asserted while a fill is outstanding
    @(posedge clk); #1;
    mem_address = 32'h0000_0640; mem_read = 1'b1;
    waited = 0; seen = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (pmem_read) seen = 1'b1;
      check("abort_no_resp", 256'(mem_resp), 256'(0));
    end
    check("abort_reached_alloc", 256'(seen), 256'(1));
    rst_n = 1'b0;
    #1;
    check("abort_pmem_read", 256'(pmem_read), 256'(0));
    check("abort_pmem_addr", 256'(pmem_address), 256'(0));
    check("abort_hits",      256'(hit_count), 256'(0));
    check("abort_misses",    256'(miss_count), 256'(0));
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pmem_read", 256'(pmem_read), 256'(0));
    check("post_rst_resp",      256'(mem_resp), 256'(0));

    // Valid bits were cleared, so 0x40 misses again
    run_req(32'h0000_0040, 1'b0, 32'h0, 256'(0), 1, 1, fill2);
    check("cold_lat",     256'(r_lat), 256'(3));
    check("cold_rd_cnt",  256'(r_pm_rd), 256'(1));
    check("cold_rd_addr", 256'(r_rd_addr), 256'(32'h40));
    check("cold_misses",  256'(miss_count), 256'(1));
    check("cold_hits",    256'(hit_count), 256'(0));

    // Saturation: hold the miss counter at all-ones across a miss lookup
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_address = 32'h0000_0840; mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sat_in_lookup", 256'(pmem_read | mem_resp), 256'(0));
    check("sat_next",      256'(dut.miss_cnt_d), 256'(32'hFFFF_FFFF));
    mem_read = 1'b0;
    @(posedge clk); #1;
    release dut.miss_cnt_q;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
